// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - two-entry skid buffer pipeline stage with valid/ready handshakes
// Registered in_ready (no out_ready path); main drives out_data, skid catches the overflow entry.
module pipe_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             accept;
   logic             pop;

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Flush wins over everything; a coincident pop is still a delivery.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_d  = in_data;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_d = in_data;
               end else if (accept) begin
                  skid_d  = in_data;
                  state_d = FULL;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  main_d  = skid_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q != FULL) && !rst;
      out_valid = (state_q != EMPTY);
      out_data  = main_q;
      case (state_q)
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - directed and random scoreboard bench for pipe_stage
// Three widths share one stimulus stream; a FIFO queue is the reference.
module tb_pipe_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] in_data;

   logic        in_ready8,  out_valid8;
   logic        in_ready32, out_valid32;
   logic        in_ready64, out_valid64;
   logic [7:0]  out_data8;
   logic [31:0] out_data32;
   logic [63:0] out_data64;
   logic [1:0]  occ8, occ32, occ64;

   int checks   = 0;
   int failures = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   pipe_stage #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready8),
      .in_data(in_data[7:0]), .out_valid(out_valid8), .out_ready(out_ready),
      .out_data(out_data8), .occupancy(occ8)
   );

   pipe_stage #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .in_data(in_data[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
      .out_data(out_data32), .occupancy(occ32)
   );

   pipe_stage #(.WIDTH(64)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .in_data(in_data), .out_valid(out_valid64), .out_ready(out_ready),
      .out_data(out_data64), .occupancy(occ64)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [63:0] front;
      int n;
      n = sb.size();
      chk("occupancy64", {62'd0, occ64}, 64'(n));
      chk("occupancy8", {62'd0, occ8}, 64'(n));
      chk("out_valid64", {63'd0, out_valid64}, {63'd0, n > 0});
      chk("out_valid32", {63'd0, out_valid32}, {63'd0, n > 0});
      chk("in_ready64", {63'd0, in_ready64}, {63'd0, (n < 2) && !rst});
      chk("in_ready32", {63'd0, in_ready32}, {63'd0, (n < 2) && !rst});
      if (n > 0) begin
         front = sb[0];
         chk("out_data64", out_data64, front);
         chk("out_data32", {32'd0, out_data32}, {32'd0, front[31:0]});
         chk("out_data8", {56'd0, out_data8}, {56'd0, front[7:0]});
      end
   endtask

   // Inputs must already be applied; checks, updates the reference, advances one clock.
   task automatic tick();
      logic acc, pp;
      #1;
      check_outputs();
      acc = in_valid && (sb.size() < 2) && !rst;
      pp  = out_ready && (sb.size() > 0);
      if (flush) begin
         sb.delete();
      end else begin
         if (pp) void'(sb.pop_front());
         if (acc) sb.push_back(in_data);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, {63'd0, out_valid64}, 64'd0);
      chk({tag, "_in_ready"}, {63'd0, in_ready64}, 64'd0);
      chk({tag, "_occupancy"}, {62'd0, occ64}, 64'd0);
      chk({tag, "_out_data64"}, out_data64, 64'd0);
      chk({tag, "_out_data8"}, {56'd0, out_data8}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      #1;
      check_reset_outputs("reset_pre_clock");
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_reset_outputs("reset_held");
      rst = 1'b0;

      // Reset then first transfer
      in_valid = 1'b1; in_data = 64'h11;
      tick();
      in_valid = 1'b0;
      tick();
      chk("first_out_data", out_data64, 64'h11);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();

      // Fill and drain
      in_valid = 1'b1; in_data = 64'hA;
      tick();
      in_data = 64'hB;
      tick();
      in_valid = 1'b0;
      chk("fill_occupancy", {62'd0, occ64}, 64'd2);
      chk("fill_in_ready", {63'd0, in_ready64}, 64'd0);
      chk("fill_out_data", out_data64, 64'hA);
      // Producer pressing while full must not disturb the held entries
      in_valid = 1'b1; in_data = 64'hDEAD;
      tick(); tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick(); tick(); tick();
      chk("drain_empty", {63'd0, out_valid64}, 64'd0);

      // Streaming 0..99
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_data = 64'(i);
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();

      // Flush while full with a coincident push
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 64'h21; tick();
      in_data = 64'h22; tick();
      chk("preflush_occupancy", {62'd0, occ64}, 64'd2);
      flush = 1'b1; in_data = 64'hC;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_occupancy", {62'd0, occ64}, 64'd0);
      chk("flush_out_valid", {63'd0, out_valid64}, 64'd0);
      out_ready = 1'b1;
      tick(); tick();

      // Flush with pop in ONE state, then refill
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h31;
      tick();
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b1; in_data = 64'h32;
      tick();
      in_valid = 1'b0;
      tick(); tick();

      // Asynchronous reset mid-cycle while full
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 64'h41; tick();
      in_data = 64'h42; tick();
      in_valid = 1'b0;
      chk("prerst_occupancy", {62'd0, occ64}, 64'd2);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      sb.delete();
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b1; in_data = 64'h55;
      tick();
      in_valid = 1'b0;
      tick(); tick();

      // Random stress, all three widths in parallel
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 1) == 1);
         in_data   = {$urandom, $urandom};
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick(); tick();
      chk("final_empty", {62'd0, occ64}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the payload width in bits; legal range 1..256.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 flush  input  1  SHALL be the synchronous clear; discards all held entries.
REQ-005 in_valid  input  1  SHALL indicate that the producer presents in_data.
REQ-006 in_ready  output  1  SHALL indicate that the stage can accept an entry this cycle.
REQ-007 in_data  input  WIDTH  SHALL be the producer payload.
REQ-008 out_valid  output  1  SHALL indicate that out_data holds a valid entry.
REQ-009 out_ready  input  1  SHALL indicate that the consumer takes out_data this cycle.
REQ-010 out_data  output  WIDTH  SHALL be the oldest held payload.
REQ-011 occupancy  output  2  SHALL give the number of held entries: 0, 1 or 2.

Function
REQ-012 Storage SHALL consist of two registers:
- main drives out_data.
- skid holds the second entry.
REQ-013 The FSM SHALL have three states:
- EMPTY: 0 entries.
- ONE: main valid.
- FULL: main and skid valid.
REQ-014 Accept SHALL occur when in_valid and in_ready are both high. Pop SHALL occur when out_valid and out_ready are both high.
REQ-015 in_ready SHALL be high iff state is not FULL and rst is low. in_ready SHALL be a registered-state function only, with no combinational path from out_ready.
REQ-016 out_valid SHALL be high iff state is not EMPTY. occupancy SHALL be 0, 1 or 2 for EMPTY, ONE or FULL respectively.
REQ-017 EMPTY transitions SHALL be:
- accept: main gets in_data, next state ONE.
- otherwise: stay EMPTY.
REQ-018 ONE transitions SHALL be:
- accept only: skid gets in_data, next state FULL.
- pop only: next state EMPTY.
- accept and pop: main gets in_data, stay ONE.
- neither: hold.
REQ-019 FULL transitions SHALL be:
- pop: main gets skid, next state ONE.
- no pop: hold.
- No accept is possible in FULL.
REQ-020 Latency from accept to out_valid SHALL be exactly 1 cycle. Sustained throughput SHALL be 1 entry/cycle when out_ready is held high.
REQ-021 Ordering SHALL be strict FIFO. No entry SHALL be duplicated or lost except by flush or rst.
REQ-022 While out_valid is high and out_ready is low, out_data SHALL remain stable.
REQ-023 flush SHALL take priority over accept and pop in the same cycle. Next state SHALL be EMPTY, and any entry accepted in the flush cycle SHALL be discarded.
REQ-024 A pop coincident with flush SHALL count as delivered. The consumer may use out_data sampled in that cycle.
REQ-025 When not FULL, in_ready SHALL not depend on in_valid. Producer behaviour when in_ready is low SHALL not affect state.

Reset
REQ-026 While rst is high, the block SHALL hold state EMPTY and the output values below, independent of clk:
- out_valid = 0
- in_ready = 0
- occupancy = 0
- out_data = 0
REQ-027 The main and skid registers SHALL reset to all zeros.
REQ-028 Assertion of rst mid-transfer SHALL discard all entries immediately.
REQ-029 After rst deasserts, in_ready SHALL be 1 from the first cycle, and the first accepted entry SHALL appear on the following cycle.

Verification
REQ-030 Reset and first transfer:
- Stimulus: rst pulse, then in_data=0x00000011 with in_valid=1 for one cycle.
- Response: out_valid=1 and out_data=0x00000011 one cycle later; occupancy=1.
REQ-031 Fill and drain:
- Stimulus: out_ready=0, then push 0xA, 0xB.
- Response: occupancy=2, in_ready=0, out_data holds 0xA.
- Stimulus: raise out_ready.
- Response: pops 0xA then 0xB on consecutive cycles, then out_valid=0.
REQ-032 Streaming:
- Stimulus: out_ready=1, push 0..99 on consecutive cycles.
- Response: 100 pops in order, one per cycle, and in_ready never drops.
REQ-033 Flush:
- Stimulus: in FULL, assert flush together with in_valid=1 and in_data=0xC.
- Response: next cycle occupancy=0 and out_valid=0; 0xC never appears.
REQ-034 Asynchronous reset mid-transfer:
- Stimulus: assert rst between clock edges while FULL.
- Response: out_valid=0 and out_data=0 immediately, and no stale entry after release.
REQ-035 Random stress:
- Stimulus: random in_valid and out_ready at 50% each, WIDTH=8 and WIDTH=64, 10k cycles.
- Response: scoreboard matches with no loss, duplication or reordering, and out_data is stable under stall.
